// File: rtl/decode_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage_if
// Description : Upstream/downstream handshake and decoded-bundle signals of
//               the decode stage. "slave" is the decode stage's view,
//               "master" is the surrounding pipeline's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface decode_stage_if #(
    parameter int XLEN = 32
);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_imm;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [4:0]      out_rd;
    logic [4:0]      out_aluop;
    logic [7:0]      out_ctrl;
    logic [2:0]      out_funct3;
    logic            out_illegal;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2,
               out_rd, out_aluop, out_ctrl, out_funct3, out_illegal
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2,
               out_rd, out_aluop, out_ctrl, out_funct3, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_stage
// Description : RV32I decode stage with one output register, valid/ready
//               handshake and load-use hazard hold-off.
//               Optional macro DECODE_MEXT_EN enables M-extension decode.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int XLEN           = 32,
    parameter int LOAD_USE_STALL = 1
) (
    input  logic          clk,
    input  logic          rst,
    decode_stage_if.slave bus
);
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_op     = 7'b0110011;
    localparam logic [6:0] c_op_imm    = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;

    localparam logic [4:0] c_alu_add  = 5'd0;
    localparam logic [4:0] c_alu_sub  = 5'd1;
    localparam logic [4:0] c_alu_and  = 5'd2;
    localparam logic [4:0] c_alu_or   = 5'd3;
    localparam logic [4:0] c_alu_xor  = 5'd4;
    localparam logic [4:0] c_alu_slt  = 5'd5;
    localparam logic [4:0] c_alu_sltu = 5'd6;
    localparam logic [4:0] c_alu_sll  = 5'd7;
    localparam logic [4:0] c_alu_srl  = 5'd8;
    localparam logic [4:0] c_alu_sra  = 5'd9;
`ifdef DECODE_MEXT_EN
    localparam logic [4:0] c_alu_mul  = 5'd16;
`endif

    localparam logic [1:0] c_stall = 2'(LOAD_USE_STALL);

    // Base ALU operation selected by funct3 (no alternate encodings).
    function automatic logic [4:0] f_base_alu(input logic [2:0] f3);
        logic [4:0] op;
        case (f3)
            3'b000:  op = c_alu_add;
            3'b001:  op = c_alu_sll;
            3'b010:  op = c_alu_slt;
            3'b011:  op = c_alu_sltu;
            3'b100:  op = c_alu_xor;
            3'b101:  op = c_alu_srl;
            3'b110:  op = c_alu_or;
            default: op = c_alu_and;
        endcase
        return op;
    endfunction

    logic [31:0]     w_instr;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_u;
    logic [XLEN-1:0] w_imm;
    logic [4:0]      w_aluop;
    logic            w_ill, w_mem_we, w_mem_re, w_pcmux, w_alumux1, w_alumux2, w_is_branch;
    logic [1:0]      w_regmux;
    logic            w_use1, w_use2, w_rd_en, w_is_lui, w_is_load;
    logic            w_held_load, w_pend, w_hit1, w_hit2, w_hazard;
    logic            w_in_ready, w_accept, w_handoff;

    logic            r_out_valid;
    logic [XLEN-1:0] r_pc, r_imm;
    logic [4:0]      r_rs1, r_rs2, r_rd, r_aluop, r_pend_rd;
    logic [7:0]      r_ctrl;
    logic [2:0]      r_funct3;
    logic            r_ill, r_is_load;
    logic [1:0]      r_cnt;

    assign w_instr = bus.in_instr;
    assign w_f3    = w_instr[14:12];
    assign w_f7    = w_instr[31:25];

    assign w_imm_i = {{(XLEN-12){w_instr[31]}}, w_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){w_instr[31]}}, w_instr[31:25], w_instr[11:7]};
    assign w_imm_b = {{(XLEN-12){w_instr[31]}}, w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0};
    assign w_imm_j = {{(XLEN-20){w_instr[31]}}, w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0};

    // U-type is sign-extended too; only widen when XLEN exceeds 32.
    if (XLEN > 32) begin : g_u_wide
        assign w_imm_u = {{(XLEN-32){w_instr[31]}}, w_instr[31:12], 12'b0};
    end else begin : g_u_narrow
        assign w_imm_u = {w_instr[31:12], 12'b0};
    end

    // Combinational decode of the presented instruction word. Opcodes with
    // instr[1:0] != 2'b11 never match a listed opcode and fall into default.
    always_comb begin
        w_ill       = 1'b0;
        w_imm       = '0;
        w_aluop     = c_alu_add;
        w_mem_we    = 1'b0;
        w_mem_re    = 1'b0;
        w_pcmux     = 1'b0;
        w_regmux    = 2'd0;
        w_alumux1   = 1'b0;
        w_alumux2   = 1'b0;
        w_is_branch = 1'b0;
        w_use1      = 1'b0;
        w_use2      = 1'b0;
        w_rd_en     = 1'b1;
        w_is_lui    = 1'b0;
        w_is_load   = 1'b0;
        case (w_instr[6:0])
            c_op_load: begin
                w_imm = w_imm_i; w_mem_re = 1'b1; w_regmux = 2'd2;
                w_alumux2 = 1'b1; w_use1 = 1'b1; w_is_load = 1'b1;
            end
            c_op_store: begin
                w_imm = w_imm_s; w_mem_we = 1'b1; w_mem_re = 1'b1;
                w_alumux2 = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_rd_en = 1'b0;
            end
            c_op_branch: begin
                // ALU forms PC+imm target; the condition comes from funct3.
                w_imm = w_imm_b; w_pcmux = 1'b1; w_alumux1 = 1'b1; w_alumux2 = 1'b1;
                w_is_branch = 1'b1; w_use1 = 1'b1; w_use2 = 1'b1; w_rd_en = 1'b0;
            end
            c_op_jal: begin
                w_imm = w_imm_j; w_pcmux = 1'b1; w_regmux = 2'd1;
                w_alumux1 = 1'b1; w_alumux2 = 1'b1;
            end
            c_op_jalr: begin
                w_imm = w_imm_i; w_pcmux = 1'b1; w_regmux = 2'd1;
                w_alumux2 = 1'b1; w_use1 = 1'b1;
            end
            c_op_op: begin
                w_use1 = 1'b1; w_use2 = 1'b1;
                if (w_f7 == 7'h00) begin
                    w_aluop = f_base_alu(w_f3);
                end else if (w_f7 == 7'h20 && w_f3 == 3'b000) begin
                    w_aluop = c_alu_sub;
                end else if (w_f7 == 7'h20 && w_f3 == 3'b101) begin
                    w_aluop = c_alu_sra;
`ifdef DECODE_MEXT_EN
                end else if (w_f7 == 7'h01) begin
                    w_aluop = c_alu_mul + {2'b00, w_f3};
`endif
                end else begin
                    w_ill = 1'b1;
                end
            end
            c_op_imm: begin
                w_imm = w_imm_i; w_alumux2 = 1'b1; w_use1 = 1'b1;
                w_aluop = f_base_alu(w_f3);
                if (w_f3 == 3'b001 && w_f7 != 7'h00) begin
                    w_ill = 1'b1;
                end else if (w_f3 == 3'b101 && w_f7 == 7'h20) begin
                    w_aluop = c_alu_sra;
                end else if (w_f3 == 3'b101 && w_f7 != 7'h00) begin
                    w_ill = 1'b1;
                end
            end
            c_op_lui: begin
                w_imm = w_imm_u; w_alumux2 = 1'b1; w_is_lui = 1'b1;
            end
            c_op_auipc: begin
                w_imm = w_imm_u; w_alumux1 = 1'b1; w_alumux2 = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        if (w_ill) begin
            w_mem_we  = 1'b0;
            w_mem_re  = 1'b0;
            w_pcmux   = 1'b0;
            w_rd_en   = 1'b0;
            w_is_load = 1'b0;
        end
    end

    // A load is pending either while held in the output register or while
    // the post-hand-off stall counter is running. x0 never matches.
    assign w_held_load = r_out_valid && r_is_load && (r_rd != 5'd0);
    assign w_pend      = (r_cnt != 2'd0);
    assign w_hit1 = (w_instr[19:15] != 5'd0) &&
                    ((w_held_load && w_instr[19:15] == r_rd) || (w_pend && w_instr[19:15] == r_pend_rd));
    assign w_hit2 = (w_instr[24:20] != 5'd0) &&
                    ((w_held_load && w_instr[24:20] == r_rd) || (w_pend && w_instr[24:20] == r_pend_rd));
    assign w_hazard = bus.in_valid && ((w_use1 && w_hit1) || (w_use2 && w_hit2));

    assign w_in_ready = !rst && !bus.flush && (!r_out_valid || bus.out_ready) && !w_hazard;
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_handoff  = r_out_valid && bus.out_ready;

    // Output register, handshake state and load-use stall bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_imm       <= '0;
            r_rs1       <= '0;
            r_rs2       <= '0;
            r_rd        <= '0;
            r_aluop     <= '0;
            r_ctrl      <= '0;
            r_funct3    <= '0;
            r_ill       <= 1'b0;
            r_is_load   <= 1'b0;
            r_cnt       <= '0;
            r_pend_rd   <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
            r_cnt       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_pc        <= bus.in_pc;
                r_imm       <= w_imm;
                r_rs1       <= w_is_lui ? 5'd0 : w_instr[19:15];
                r_rs2       <= w_instr[24:20];
                r_rd        <= w_rd_en ? w_instr[11:7] : 5'd0;
                r_aluop     <= w_aluop;
                r_ctrl      <= {w_mem_we, w_mem_re, w_pcmux, w_regmux,
                                w_alumux1, w_alumux2, w_is_branch};
                r_funct3    <= w_f3;
                r_ill       <= w_ill;
                r_is_load   <= w_is_load;
            end else if (w_handoff) begin
                r_out_valid <= 1'b0;
            end
            if (w_handoff && w_held_load) begin
                r_pend_rd <= r_rd;
                r_cnt     <= c_stall;
            end else if (r_cnt != 2'd0) begin
                r_cnt <= r_cnt - 2'd1;
            end
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_pc      = r_pc;
    assign bus.out_imm     = r_imm;
    assign bus.out_rs1     = r_rs1;
    assign bus.out_rs2     = r_rs2;
    assign bus.out_rd      = r_rd;
    assign bus.out_aluop   = r_aluop;
    assign bus.out_ctrl    = r_ctrl;
    assign bus.out_funct3  = r_funct3;
    assign bus.out_illegal = r_ill;
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_stage
// Description : Randomized scoreboard bench for decode_stage with a
//               behavioural decode/hazard reference model.
//               Honours macro DECODE_MEXT_EN in the reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    localparam int XLEN  = 64;
    localparam int STALL = 1;
    localparam int NCYC  = 4000;
    localparam int BW    = 2*XLEN + 32;

    typedef struct {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1, rs2, rd, aluop;
        logic [7:0]      ctrl;
        logic [2:0]      f3;
        logic            ill;
        bit              imm_chk;
        bit              is_load;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(XLEN)) bus();
    decode_stage #(.XLEN(XLEN), .LOAD_USE_STALL(STALL)) dut (.clk(clk), .rst(rst), .bus(bus));

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];
    int   alu_tab[8] = '{0, 7, 5, 6, 4, 8, 3, 2};   // ADD SLL SLT SLTU XOR SRL OR AND

    // Reference-model state: held bundle and pending load window.
    exp_t        held;
    bit          held_v = 0;
    int          k = 0;
    int          pend_end = -1;
    logic [4:0]  pend_rd = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Instruction semantics straight from the ISA field layout.
    function automatic exp_t ref_decode(input logic [31:0] ins, input logic [XLEN-1:0] pc);
        exp_t e; longint v; logic [6:0] f7; logic [2:0] f3;
        bit we, re, pcm, a1, a2, br; logic [1:0] rm;
        we = 0; re = 0; pcm = 0; a1 = 0; a2 = 0; br = 0; rm = 0; v = 0;
        f7 = ins[31:25]; f3 = ins[14:12];
        e.pc = pc; e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.aluop = 0; e.f3 = f3; e.ill = 0; e.imm_chk = 1; e.is_load = 0;
        case (ins[6:0])
            7'h03: begin v = longint'($signed(ins[31:20])); re = 1; rm = 2; a2 = 1; e.is_load = 1; end
            7'h23: begin v = longint'($signed({ins[31:25], ins[11:7]})); we = 1; re = 1; a2 = 1; e.rd = 0; end
            7'h63: begin
                v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                pcm = 1; a1 = 1; a2 = 1; br = 1; e.rd = 0;
            end
            7'h6f: begin
                v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                pcm = 1; rm = 1; a1 = 1; a2 = 1;
            end
            7'h67: begin v = longint'($signed(ins[31:20])); pcm = 1; rm = 1; a2 = 1; end
            7'h33: begin
                e.imm_chk = 0;
                if (f7 == 7'h00) e.aluop = 5'(alu_tab[f3]);
                else if (f7 == 7'h20 && f3 == 3'd0) e.aluop = 5'd1;
                else if (f7 == 7'h20 && f3 == 3'd5) e.aluop = 5'd9;
`ifdef DECODE_MEXT_EN
                else if (f7 == 7'h01) e.aluop = 5'(16 + int'(f3));
`endif
                else e.ill = 1;
            end
            7'h13: begin
                v = longint'($signed(ins[31:20])); a2 = 1;
                if (f3 == 3'd1) begin
                    if (f7 == 7'h00) e.aluop = 5'd7; else e.ill = 1;
                end else if (f3 == 3'd5) begin
                    if (f7 == 7'h00) e.aluop = 5'd8;
                    else if (f7 == 7'h20) e.aluop = 5'd9;
                    else e.ill = 1;
                end else e.aluop = 5'(alu_tab[f3]);
            end
            7'h37: begin v = longint'($signed({ins[31:12], 12'h000})); a2 = 1; e.rs1 = 0; end
            7'h17: begin v = longint'($signed({ins[31:12], 12'h000})); a1 = 1; a2 = 1; end
            default: e.ill = 1;
        endcase
        if (e.ill) begin we = 0; re = 0; pcm = 0; e.rd = 0; e.is_load = 0; end
        e.imm  = v[XLEN-1:0];
        e.ctrl = {we, re, pcm, rm, a1, a2, br};
        return e;
    endfunction

    function automatic bit uses1(input logic [31:0] ins);
        return ins[6:0] inside {7'h03, 7'h23, 7'h63, 7'h67, 7'h33, 7'h13};
    endfunction
    function automatic bit uses2(input logic [31:0] ins);
        return ins[6:0] inside {7'h23, 7'h63, 7'h33};
    endfunction
    function automatic bit src_hit(input logic [4:0] s);
        return (s != 0) && ((held_v && held.is_load && held.rd != 0 && s == held.rd) ||
                            (k <= pend_end && s == pend_rd));
    endfunction
    function automatic bit model_hazard();
        return bus.in_valid && ((uses1(bus.in_instr) && src_hit(bus.in_instr[19:15])) ||
                                (uses2(bus.in_instr) && src_hit(bus.in_instr[24:20])));
    endfunction

    function automatic logic [BW-1:0] cur_bundle();
        return {bus.out_pc, bus.out_imm, bus.out_rs1, bus.out_rs2, bus.out_rd,
                bus.out_aluop, bus.out_ctrl, bus.out_funct3, bus.out_illegal};
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [4:0] a, b, d; logic [2:0] f3; logic [6:0] f7; logic [31:0] r;
        a = 5'($urandom_range(0, 3)); b = 5'($urandom_range(0, 3)); d = 5'($urandom_range(0, 3));
        f3 = 3'($urandom_range(0, 7)); r = $urandom;
        case ($urandom_range(0, 9))
            0: return {r[31:20], a, 3'b010, d, 7'h03};
            1: return {r[31:25], b, a, 3'b010, r[11:7], 7'h23};
            2: return {r[31:25], b, a, f3, r[11:7], 7'h63};
            3: return {r[31:12], d, 7'h6f};
            4: return {r[31:20], a, 3'b000, d, 7'h67};
            5: begin
                case ($urandom_range(0, 3))
                    0: f7 = 7'h00; 1: f7 = 7'h20; 2: f7 = 7'h01; default: f7 = r[31:25];
                endcase
                return {f7, b, a, f3, d, 7'h33};
            end
            6: begin
                case ($urandom_range(0, 2))
                    0: f7 = 7'h00; 1: f7 = 7'h20; default: f7 = r[31:25];
                endcase
                if (f3 == 3'd1 || f3 == 3'd5) return {f7, r[24:20], a, f3, d, 7'h13};
                return {r[31:20], a, f3, d, 7'h13};
            end
            7: return {r[31:12], d, 7'h37};
            8: return {r[31:12], d, 7'h17};
            default: return r;
        endcase
    endfunction

    // Monitor: every hand-off pops and checks the oldest expected bundle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && !bus.flush && bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_bundle", 64'd1, 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("out_pc", bus.out_pc, e.pc);
                    chk("out_funct3", bus.out_funct3, e.f3);
                    chk("out_illegal", bus.out_illegal, e.ill);
                    chk("out_rd", bus.out_rd, e.rd);
                    if (e.ill) begin
                        chk("illegal_we_re_pcmux", bus.out_ctrl & 8'hE0, 64'd0);
                    end else begin
                        chk("out_rs1", bus.out_rs1, e.rs1);
                        chk("out_rs2", bus.out_rs2, e.rs2);
                        chk("out_aluop", bus.out_aluop, e.aluop);
                        chk("out_ctrl", bus.out_ctrl, e.ctrl);
                        if (e.imm_chk) chk("out_imm", bus.out_imm, e.imm);
                    end
                end
            end
        end
    end

    // Stimulus driver plus handshake/hazard reference model.
    initial begin
        logic [31:0]     dir[6];
        int              d_idx;
        logic [XLEN-1:0] pcv;
        bit              acc, hand, q_clear, q_push, stall_prev, exp_rdy;
        exp_t            push_e;
        logic [BW-1:0]   snap;

        dir[0] = 32'hFFF00093;   // addi x1,x0,-1
        dir[1] = 32'h00012283;   // lw   x5,0(x2)
        dir[2] = 32'h00528333;   // add  x6,x5,x5
        dir[3] = 32'h02208033;   // mul  x0,x1,x2
        dir[4] = 32'h800001B7;   // lui  x3,0x80000
        dir[5] = 32'h0002A203;   // lw   x4,0(x5)
        acc = 0; q_clear = 0; q_push = 0; stall_prev = 0; snap = '0;
        pcv = XLEN'({$urandom, $urandom}) & ~XLEN'(3);

        rst = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b0;
        bus.in_valid = 1'b1; bus.in_instr = dir[0]; bus.in_pc = pcv; d_idx = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 64'd0);
        chk("rst_out_valid", bus.out_valid, 64'd0);
        chk("rst_out_imm", bus.out_imm, 64'd0);
        chk("rst_out_pc", bus.out_pc, 64'd0);
        chk("rst_out_ctrl", bus.out_ctrl, 64'd0);
        chk("rst_out_aluop", bus.out_aluop, 64'd0);
        chk("rst_out_rd", bus.out_rd, 64'd0);

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            if (q_clear) sb.delete();
            if (q_push) sb.push_back(push_e);
            q_clear = 0; q_push = 0;
            #1;
            rst = (c >= 2000 && c < 2002);
            if (!(bus.in_valid && !acc)) begin
                pcv = pcv + XLEN'(4);
                bus.in_pc = pcv;
                if (d_idx < 6) begin
                    bus.in_valid = 1'b1; bus.in_instr = dir[d_idx]; d_idx++;
                end else begin
                    bus.in_valid = ($urandom_range(0, 9) < 8); bus.in_instr = gen_instr();
                end
            end
            if (c >= NCYC - 10) bus.in_valid = 1'b0;
            if (c < 8) bus.out_ready = 1'b1;
            else if (c < 11) bus.out_ready = 1'b0;
            else bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush = (c >= 12 && c < NCYC - 10 && !rst && $urandom_range(0, 29) == 0);
            if (bus.flush || rst) bus.out_ready = 1'b0;
            if (c >= NCYC - 10) bus.out_ready = 1'b1;

            @(negedge clk);
            exp_rdy = !rst && !bus.flush && (!held_v || bus.out_ready) && !model_hazard();
            chk("in_ready", bus.in_ready, exp_rdy);
            chk("out_valid", bus.out_valid, held_v);
            if (stall_prev) begin
                n_vec++;
                if (cur_bundle() !== snap) begin
                    n_err++;
                    $display("FAIL hold_stable: got %h expected %h at %0t", cur_bundle(), snap, $time);
                end
            end
            stall_prev = bus.out_valid && !bus.out_ready && !bus.flush && !rst;
            snap = cur_bundle();
            acc  = bus.in_valid && bus.in_ready;
            hand = bus.out_valid && bus.out_ready;
            if (rst || bus.flush) begin
                held_v = 0; pend_end = -1; q_clear = 1;
            end else begin
                if (hand && held_v && held.is_load && held.rd != 0) begin
                    pend_rd = held.rd; pend_end = k + STALL;
                end
                if (acc) begin
                    held = ref_decode(bus.in_instr, bus.in_pc);
                    held_v = 1; q_push = 1; push_e = held;
                end else if (hand) begin
                    held_v = 0;
                end
            end
            k++;
        end

        @(negedge clk);
        chk("drain_empty", sb.size(), 64'd0);
        chk("drain_out_valid", bus.out_valid, 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
